// File: rtl/pe_share_arbiter.sv
// pe_share_arbiter
// Two requesters share a single accumulate PE. One requester owns the PE for
// a whole burst: its operand beats are forwarded (one cycle late) to the PE,
// the PE is then drained, and the captured result and beat count are returned
// to the owner with a one-cycle response strobe.
//
// Build option: define PE_ARB_RR_EN to break request ties round-robin.
// Without it, requester 0 always wins a tie and no pointer state exists.

module pe_share_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        r0_req_i,
    input  logic        r1_req_i,
    output logic        r0_gnt_o,
    output logic        r1_gnt_o,

    input  logic        r0_vld_i,
    input  logic [15:0] r0_a_i,
    input  logic [15:0] r0_b_i,
    input  logic        r0_last_i,
    input  logic        r1_vld_i,
    input  logic [15:0] r1_a_i,
    input  logic [15:0] r1_b_i,
    input  logic        r1_last_i,

    output logic        pe_ctrl_o,
    output logic [15:0] pe_wgt_o,
    output logic [15:0] pe_ipt_o,
    input  logic [15:0] pe_result_i,
    input  logic        pe_finish_i,

    output logic [15:0] rsp_data_o,
    output logic [7:0]  rsp_len_o,
    output logic        r0_rsp_vld_o,
    output logic        r1_rsp_vld_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Control state
    state_e      state_q;
    logic        owner_q;      // 0 = requester 0, 1 = requester 1
    logic [7:0]  beat_q;
`ifdef PE_ARB_RR_EN
    logic        rr_ptr_q;     // requester that wins the next tie
`endif

    // Registered outputs
    logic        r0_gnt_q;
    logic        r1_gnt_q;
    logic        pe_ctrl_q;
    logic [15:0] pe_wgt_q;
    logic [15:0] pe_ipt_q;
    logic [15:0] rsp_data_q;
    logic [7:0]  rsp_len_q;
    logic        r0_rsp_vld_q;
    logic        r1_rsp_vld_q;
    logic        busy_q;

    // Combinational helpers
    logic        any_req;
    logic        win_d;
    logic        own_vld;
    logic        own_last;
    logic [15:0] own_a;
    logic [15:0] own_b;
    logic [7:0]  beat_d;

    // Pick the requester that gets the next burst
    always_comb begin
        any_req = r0_req_i | r1_req_i;
`ifdef PE_ARB_RR_EN
        win_d   = (r0_req_i && r1_req_i) ? rr_ptr_q : ~r0_req_i;
`else
        win_d   = ~r0_req_i;
`endif
    end

    // Steer the owner's beat signals; the other side is never observed
    always_comb begin
        own_vld  = owner_q ? r1_vld_i  : r0_vld_i;
        own_last = owner_q ? r1_last_i : r0_last_i;
        own_a    = owner_q ? r1_a_i    : r0_a_i;
        own_b    = owner_q ? r1_b_i    : r0_b_i;
    end

    // Beat count increment, pinned at 255 so long bursts report saturation
    always_comb begin
        beat_d = (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;
    end

    // Burst FSM; all outputs are registered here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            beat_q       <= 8'd0;
`ifdef PE_ARB_RR_EN
            rr_ptr_q     <= 1'b0;
`endif
            r0_gnt_q     <= 1'b0;
            r1_gnt_q     <= 1'b0;
            pe_ctrl_q    <= 1'b0;
            pe_wgt_q     <= 16'd0;
            pe_ipt_q     <= 16'd0;
            rsp_data_q   <= 16'd0;
            rsp_len_q    <= 8'd0;
            r0_rsp_vld_q <= 1'b0;
            r1_rsp_vld_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // PE is flushed with zero operands unless a beat is forwarded
            pe_ctrl_q    <= 1'b0;
            pe_wgt_q     <= 16'd0;
            pe_ipt_q     <= 16'd0;
            r0_rsp_vld_q <= 1'b0;
            r1_rsp_vld_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_q  <= win_d;
                        r0_gnt_q <= ~win_d;
                        r1_gnt_q <= win_d;
                        beat_q   <= 8'd0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_STREAM;
                    end
                end

                ST_STREAM: begin
                    // Dropping req here is deliberately ignored; only last ends a burst
                    if (own_vld) begin
                        pe_ctrl_q <= 1'b1;
                        pe_wgt_q  <= own_a;
                        pe_ipt_q  <= own_b;
                        beat_q    <= beat_d;
                        if (own_last) begin
                            r0_gnt_q <= 1'b0;
                            r1_gnt_q <= 1'b0;
                            state_q  <= ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (pe_finish_i) begin
                        rsp_data_q   <= pe_result_i;
                        rsp_len_q    <= beat_q;
                        r0_rsp_vld_q <= ~owner_q;
                        r1_rsp_vld_q <= owner_q;
                        state_q      <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
`ifdef PE_ARB_RR_EN
                    rr_ptr_q <= ~owner_q;
`endif
                end

                default: begin
                    r0_gnt_q <= 1'b0;
                    r1_gnt_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign r0_gnt_o     = r0_gnt_q;
    assign r1_gnt_o     = r1_gnt_q;
    assign pe_ctrl_o    = pe_ctrl_q;
    assign pe_wgt_o     = pe_wgt_q;
    assign pe_ipt_o     = pe_ipt_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_len_o    = rsp_len_q;
    assign r0_rsp_vld_o = r0_rsp_vld_q;
    assign r1_rsp_vld_o = r1_rsp_vld_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_pe_share_arbiter.sv
// Bench for pe_share_arbiter: table of single-requester bursts, an arbitration
// sequence with both requests held, and a reset-in-DRAIN sequence. Responses
// are checked through a scoreboard queue filled when pe_finish is driven.

module tb_pe_share_arbiter;

    logic        clk;
    logic        rst;
    logic        r0_req, r1_req;
    logic        r0_gnt_o, r1_gnt_o;
    logic        r0_vld, r1_vld;
    logic [15:0] r0_a, r0_b, r1_a, r1_b;
    logic        r0_last, r1_last;
    logic        pe_ctrl_o;
    logic [15:0] pe_wgt_o, pe_ipt_o;
    logic [15:0] pe_result;
    logic        pe_finish;
    logic [15:0] rsp_data_o;
    logic [7:0]  rsp_len_o;
    logic        r0_rsp_vld_o, r1_rsp_vld_o;
    logic        busy_o;

    typedef struct {
        logic        who;
        int          n;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [7:0]  len;
        logic        noise;
        logic        inc;
        logic        bubble;
    } vec_t;

    typedef struct {
        logic        who;
        logic [15:0] data;
        logic [7:0]  len;
    } rsp_t;

    vec_t vt [6];
    rsp_t sb [$];
    int   n_tests, n_fail, cyc;
    logic exp_ord [4];

    pe_share_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .r0_req_i     (r0_req),
        .r1_req_i     (r1_req),
        .r0_gnt_o     (r0_gnt_o),
        .r1_gnt_o     (r1_gnt_o),
        .r0_vld_i     (r0_vld),
        .r0_a_i       (r0_a),
        .r0_b_i       (r0_b),
        .r0_last_i    (r0_last),
        .r1_vld_i     (r1_vld),
        .r1_a_i       (r1_a),
        .r1_b_i       (r1_b),
        .r1_last_i    (r1_last),
        .pe_ctrl_o    (pe_ctrl_o),
        .pe_wgt_o     (pe_wgt_o),
        .pe_ipt_o     (pe_ipt_o),
        .pe_result_i  (pe_result),
        .pe_finish_i  (pe_finish),
        .rsp_data_o   (rsp_data_o),
        .rsp_len_o    (rsp_len_o),
        .r0_rsp_vld_o (r0_rsp_vld_o),
        .r1_rsp_vld_o (r1_rsp_vld_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock, sample 1ns after the edge, and retire any response
    task automatic tick();
        rsp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (r0_rsp_vld_o || r1_rsp_vld_o) begin
            check("rsp_onehot", 32'(r0_rsp_vld_o & r1_rsp_vld_o), 32'd0);
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'({r1_rsp_vld_o, r0_rsp_vld_o}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_owner", 32'(r1_rsp_vld_o), 32'(e.who));
                check("rsp_data", 32'(rsp_data_o), 32'(e.data));
                check("rsp_len", 32'(rsp_len_o), 32'(e.len));
            end
        end
    endtask

    task automatic set_req(input logic who, input logic v);
        if (who) r1_req = v;
        else     r0_req = v;
    endtask

    task automatic drive_beat(input logic who, input logic vld, input logic [15:0] a,
                              input logic [15:0] b, input logic last);
        if (who) begin
            r1_vld = vld; r1_a = a; r1_b = b; r1_last = last;
        end else begin
            r0_vld = vld; r0_a = a; r0_b = b; r0_last = last;
        end
    endtask

    function automatic logic gnt_of(input logic who);
        return who ? r1_gnt_o : r0_gnt_o;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ":r0_gnt"},   32'(r0_gnt_o), 32'd0);
        check({tag, ":r1_gnt"},   32'(r1_gnt_o), 32'd0);
        check({tag, ":pe_ctrl"},  32'(pe_ctrl_o), 32'd0);
        check({tag, ":pe_wgt"},   32'(pe_wgt_o), 32'd0);
        check({tag, ":pe_ipt"},   32'(pe_ipt_o), 32'd0);
        check({tag, ":rsp_data"}, 32'(rsp_data_o), 32'd0);
        check({tag, ":rsp_len"},  32'(rsp_len_o), 32'd0);
        check({tag, ":r0_rsp"},   32'(r0_rsp_vld_o), 32'd0);
        check({tag, ":r1_rsp"},   32'(r1_rsp_vld_o), 32'd0);
        check({tag, ":busy"},     32'(busy_o), 32'd0);
    endtask

    // One complete burst from IDLE back to IDLE for a single requester
    task automatic run_burst(input vec_t v);
        logic [15:0] a, b;
        set_req(v.who, 1'b1);
        tick();
        check("gnt_latency", 32'(gnt_of(v.who)), 32'd1);
        check("gnt_other", 32'(gnt_of(~v.who)), 32'd0);
        check("busy_stream", 32'(busy_o), 32'd1);
        set_req(v.who, 1'b0);
        pe_finish = 1'b1;
        pe_result = 16'hDEAD;
        if (v.noise) drive_beat(~v.who, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        for (int i = 0; i < v.n; i++) begin
            a = v.a + (v.inc ? 16'(i) : 16'd0);
            b = v.b + (v.inc ? 16'(i) : 16'd0);
            drive_beat(v.who, 1'b1, a, b, (i == v.n - 1));
            tick();
            check("pe_ctrl_beat", 32'(pe_ctrl_o), 32'd1);
            check("pe_wgt_beat", 32'(pe_wgt_o), 32'(a));
            check("pe_ipt_beat", 32'(pe_ipt_o), 32'(b));
            check("gnt_hold", 32'(gnt_of(v.who)), 32'(i != v.n - 1));
            if (v.bubble && i == 0 && v.n > 1) begin
                drive_beat(v.who, 1'b0, 16'h5A5A, 16'hA5A5, 1'b0);
                tick();
                check("pe_ctrl_bubble", 32'(pe_ctrl_o), 32'd0);
                check("pe_wgt_bubble", 32'(pe_wgt_o), 32'd0);
                check("pe_ipt_bubble", 32'(pe_ipt_o), 32'd0);
                check("gnt_bubble", 32'(gnt_of(v.who)), 32'd1);
            end
        end
        // DRAIN: owner beats must not reach the PE
        drive_beat(v.who, 1'b1, 16'h1234, 16'h4321, 1'b1);
        pe_finish = 1'b0;
        tick();
        check("pe_ctrl_drain", 32'(pe_ctrl_o), 32'd0);
        check("pe_wgt_drain", 32'(pe_wgt_o), 32'd0);
        check("gnt_drain", 32'(gnt_of(v.who)), 32'd0);
        check("busy_drain", 32'(busy_o), 32'd1);
        drive_beat(v.who, 1'b0, 16'd0, 16'd0, 1'b0);
        drive_beat(~v.who, 1'b0, 16'd0, 16'd0, 1'b0);
        pe_finish = 1'b1;
        pe_result = v.res;
        sb.push_back('{v.who, v.res, v.len});
        tick();
        check("rsp_pending", 32'(sb.size()), 32'd0);
        pe_finish = 1'b0;
        pe_result = 16'h0BAD;
        tick();
        check("busy_idle", 32'(busy_o), 32'd0);
        check("rsp_data_hold", 32'(rsp_data_o), 32'(v.res));
        check("rsp_len_hold", 32'(rsp_len_o), 32'(v.len));
    endtask

    // A 1-beat burst after the grant has been observed
    task automatic one_beat(input logic who, input logic [15:0] res);
        drive_beat(who, 1'b1, 16'h0100 + res, 16'h0002, 1'b1);
        tick();
        check("arb_pe_wgt", 32'(pe_wgt_o), 32'(16'h0100 + res));
        drive_beat(who, 1'b0, 16'd0, 16'd0, 1'b0);
        pe_finish = 1'b1;
        pe_result = res;
        sb.push_back('{who, res, 8'd1});
        tick();
        check("arb_rsp_pending", 32'(sb.size()), 32'd0);
        pe_finish = 1'b0;
        tick();
    endtask

    initial begin
        logic got, who;
        n_tests = 0; n_fail = 0; cyc = 0;
        rst = 1'b0;
        r0_req = 0; r1_req = 0;
        r0_vld = 0; r0_a = 0; r0_b = 0; r0_last = 0;
        r1_vld = 0; r1_a = 0; r1_b = 0; r1_last = 0;
        pe_result = 0; pe_finish = 0;

        //          who   n    a        b        res       len    noise inc   bubble
        vt[0] = '{1'b0, 3,   16'd2,   16'd3,   16'd18,   8'd3,   1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 2,   16'h00AB,16'h0101,16'hBEEF, 8'd2,   1'b1, 1'b1, 1'b1};
        vt[2] = '{1'b0, 4,   16'h1234,16'h5678,16'h7777, 8'd4,   1'b1, 1'b1, 1'b1};
        vt[3] = '{1'b1, 1,   16'hFFFE,16'h0001,16'h0000, 8'd1,   1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b0, 300, 16'h0001,16'h0001,16'h012C, 8'd255, 1'b0, 1'b1, 1'b0};
        vt[5] = '{1'b1, 256, 16'h0010,16'h0020,16'h4242, 8'd255, 1'b1, 1'b1, 1'b1};

`ifdef PE_ARB_RR_EN
        exp_ord[0] = 1'b0; exp_ord[1] = 1'b1; exp_ord[2] = 1'b0; exp_ord[3] = 1'b1;
`else
        exp_ord[0] = 1'b0; exp_ord[1] = 1'b0; exp_ord[2] = 1'b1; exp_ord[3] = 1'b1;
`endif

        // Reset values, with a request pending that must not be acted on
        r0_req = 1'b1;
        repeat (3) tick();
        check_zero("reset");
        r0_req = 1'b0;
        #2 rst = 1'b1;

        for (int v = 0; v < 6; v++) run_burst(vt[v]);

        // Both requests held: grant order depends on tie-break mode
        r0_req = 1'b1;
        r1_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
`ifndef PE_ARB_RR_EN
            if (g == 2) r0_req = 1'b0;
`endif
            got = 1'b0;
            for (int k = 0; k < 6 && !got; k++) begin
                tick();
                got = r0_gnt_o | r1_gnt_o;
            end
            check("arb_grant_seen", 32'(got), 32'd1);
            if (got) begin
                who = r1_gnt_o;
                check("arb_order", 32'(who), 32'(exp_ord[g]));
                check("arb_gnt_onehot", 32'(r0_gnt_o & r1_gnt_o), 32'd0);
                one_beat(who, 16'(g + 1));
            end
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        tick();
        check("arb_idle", 32'(busy_o), 32'd0);

        // Reset asserted in DRAIN while pe_finish is high: burst is abandoned
        r0_req = 1'b1;
        tick();
        check("rd_gnt", 32'(r0_gnt_o), 32'd1);
        r0_req = 1'b0;
        drive_beat(1'b0, 1'b1, 16'h0007, 16'h0008, 1'b1);
        tick();
        check("rd_in_drain", 32'(busy_o), 32'd1);
        drive_beat(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        pe_finish = 1'b1;
        pe_result = 16'h0055;
        #2 rst = 1'b0;
        #1 check_zero("rst_async");
        r0_req = 1'b1;
        tick();
        check_zero("rst_held");
        #2 rst = 1'b1;
        r0_req = 1'b0;
        pe_finish = 1'b0;
        tick();
        check_zero("rst_release");

        // First burst after reset behaves normally
        run_burst(vt[0]);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
